countdown_timer4: RTL and testbench
===================================

COUNTDOWN_TIMER4 -- requirements
Module: countdown_timer4

Interface
REQ-001 Parameter: AUTO_RELOAD, default 0; 1 = on expiry, restart from the last loaded value.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: load_valid  input  1  start request carrying load_value.
REQ-005 Port: load_value  input  4  unsigned start count, 0..15.
REQ-006 Port: load_ready  output  1  high only in IDLE; a load is accepted on an edge where load_valid and load_ready are both high.
REQ-007 Port: pause  input  1  hold count while in RUN.
REQ-008 Port: abort  input  1  cancel a running count.
REQ-009 Port: count  output  4  current count register.
REQ-010 Port: busy  output  1  high in RUN.
REQ-011 Port: done  output  1  single-cycle expiry pulse, high in DONE.

Function
REQ-012 The next-count value SHALL come from an instance of the existing gate-level decrementer4bit (input count, output d); no behavioural subtract.
REQ-013 States SHALL be IDLE, RUN and DONE; the outputs are decoded from state: load_ready=IDLE, busy=RUN, done=DONE.
REQ-014 IDLE, accepted load of V: count<=V and reload_reg<=V; next state DONE if V==0, else RUN.
REQ-015 IDLE, load_valid low: state and count hold.
REQ-016 RUN, abort=1: count<=0, next state IDLE, no done pulse; abort has priority over pause and over decrement.
REQ-017 RUN, abort=0, pause=1: count and state hold.
REQ-018 RUN, abort=0, pause=0, count>1: count<=d (count-1); stay in RUN.
REQ-019 RUN, abort=0, pause=0, count==1: count<=0; next state DONE.
REQ-020 count SHALL never wrap. The decrementer output for count==0 (4'hF) SHALL never be stored.
REQ-021 Latency: after a load of V>0 at edge E with no pause, done SHALL be high in the cycle following edge E+V, with count==0; each paused cycle adds one cycle.
REQ-022 DONE lasts exactly one cycle. If AUTO_RELOAD==0, next state is IDLE and count stays 0.
REQ-023 DONE with AUTO_RELOAD==1 and reload_reg>0: count<=reload_reg, next state RUN.
REQ-024 DONE with AUTO_RELOAD==1 and reload_reg==0: next state IDLE.
REQ-025 load_valid SHALL be ignored outside IDLE; abort and pause SHALL be ignored outside RUN.
REQ-026 There are no combinational paths from inputs to outputs; every output is a function of registers only.

Reset
REQ-027 When rst=1 at an edge: state<=IDLE, count<=0, reload_reg<=0. As a result load_ready=1, busy=0 and done=0 after that edge.
REQ-028 Reset SHALL take priority over every other input in every state, including mid-count and during DONE; no done pulse results from a reset.
REQ-029 Before the first reset edge, output values are unspecified; the bench SHALL assert rst for at least 2 cycles.

Verification
REQ-030 Load 5, no pause -> count 5,4,3,2,1,0 on consecutive cycles; done high for exactly 1 cycle with count==0; then load_ready=1.
REQ-031 Load 0 -> done high in the cycle right after acceptance; busy never high; next cycle IDLE.
REQ-032 Load 3, pause high for 2 cycles while count==2 -> count holds at 2 for 2 cycles; done arrives 2 cycles later than in the unpaused case.
REQ-033 Load 15; assert abort and pause together at count==9 -> count=0, IDLE, done never asserted. Repeat with rst instead of abort at count==9 -> same result next cycle.
REQ-034 AUTO_RELOAD=1, load 2 -> count 2,1,0(done),2,1,0(done)... indefinitely. Abort in RUN returns to IDLE.
REQ-035 load_valid held high through RUN and DONE with a different load_value -> value ignored until IDLE. Exhaustive sweep of V=0..15 checks that the done latency equals max(V,0)+1 cycles.

Source files
------------

// File: rtl/countdown_timer4.sv
// countdown_timer4: loadable 4-bit down-counter with IDLE/RUN/DONE sequencing.
// The next count comes from a gate-level decrementer. Count never wraps below
// zero. AUTO_RELOAD=1 restarts from the last loaded value after each expiry.

// Gate-level 4-bit decrementer: d = count - 1, ripple-borrow chain.
module decrementer4bit (
  input  logic [3:0] count,
  output logic [3:0] d
);
  logic [2:0] w_borrow;

  // Borrow into bit n+1 exists only when every lower bit is zero.
  assign w_borrow[0] = ~count[0];
  assign w_borrow[1] = ~count[1] & w_borrow[0];
  assign w_borrow[2] = ~count[2] & w_borrow[1];

  assign d[0] = ~count[0];
  assign d[1] = count[1] ^ w_borrow[0];
  assign d[2] = count[2] ^ w_borrow[1];
  assign d[3] = count[3] ^ w_borrow[2];
endmodule

module countdown_timer4 #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [3:0] load_value,
  output logic       load_ready,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic [3:0] r_reload;
  logic [3:0] w_reload_nxt;
  logic [3:0] w_dec;
  logic       r_load_ready;
  logic       r_busy;
  logic       r_done;

  decrementer4bit u_dec (
    .count (r_count),
    .d     (w_dec)
  );

  // Next-state, next-count and reload-value selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    case (r_state)
      StIdle: begin
        if (load_valid) begin
          w_count_nxt  = load_value;
          w_reload_nxt = load_value;
          w_state_nxt  = (load_value == 4'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          w_count_nxt = 4'd0;
          w_state_nxt = StIdle;
        end else if (!pause) begin
          // At count<=1 force zero so the decrementer's 4'hF never lands.
          if (r_count > 4'd1) begin
            w_count_nxt = w_dec;
          end else begin
            w_count_nxt = 4'd0;
            w_state_nxt = StDone;
          end
        end
      end
      StDone: begin
        if (AUTO_RELOAD && (r_reload != 4'd0)) begin
          w_count_nxt = r_reload;
          w_state_nxt = StRun;
        end else begin
          w_count_nxt = 4'd0;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_count_nxt = 4'd0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State, count, reload and registered state-decoded outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_count      <= 4'd0;
      r_reload     <= 4'd0;
      r_load_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_reload     <= w_reload_nxt;
      r_load_ready <= (w_state_nxt == StIdle);
      r_busy       <= (w_state_nxt == StRun);
      r_done       <= (w_state_nxt == StDone);
    end
  end

  assign load_ready = r_load_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign count      = r_count;

endmodule

// File: tb/tb_countdown_timer4.sv
// Directed bench for countdown_timer4: one instance with AUTO_RELOAD=0 and one
// with AUTO_RELOAD=1. Status is compared as {load_ready, busy, done, count}.
module tb_countdown_timer4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_load_valid = 1'b0;
  logic [3:0] m_load_value = 4'd0;
  logic       m_pause = 1'b0;
  logic       m_abort = 1'b0;
  logic       m_load_ready, m_busy, m_done;
  logic [3:0] m_count;
  logic       a_load_valid = 1'b0;
  logic [3:0] a_load_value = 4'd0;
  logic       a_pause = 1'b0;
  logic       a_abort = 1'b0;
  logic       a_load_ready, a_busy, a_done;
  logic [3:0] a_count;

  int checks = 0;
  int errors = 0;
  logic [6:0] n;

  always #5 clk = ~clk;

  countdown_timer4 #(.AUTO_RELOAD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (m_load_valid),
    .load_value (m_load_value),
    .load_ready (m_load_ready),
    .pause      (m_pause),
    .abort      (m_abort),
    .count      (m_count),
    .busy       (m_busy),
    .done       (m_done)
  );

  countdown_timer4 #(.AUTO_RELOAD(1'b1)) dut_ar (
    .clk        (clk),
    .rst        (rst),
    .load_valid (a_load_valid),
    .load_value (a_load_value),
    .load_ready (a_load_ready),
    .pause      (a_pause),
    .abort      (a_abort),
    .count      (a_count),
    .busy       (a_busy),
    .done       (a_done)
  );

  wire [6:0] m_obs = {m_load_ready, m_busy, m_done, m_count};
  wire [6:0] a_obs = {a_load_ready, a_busy, a_done, a_count};

  function automatic logic [6:0] st(input logic r, input logic b, input logic d,
                                    input logic [3:0] c);
    return {r, b, d, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset for two edges.
    tick();
    tick();
    rst = 1'b0;
    chk("reset_m", m_obs, st(1, 0, 0, 0));
    chk("reset_a", a_obs, st(1, 0, 0, 0));

    // Load 5: 5,4,3,2,1 then done with 0, then idle.
    m_load_valid = 1'b1; m_load_value = 4'd5;
    tick();
    m_load_valid = 1'b0;
    for (int i = 5; i >= 1; i--) begin
      chk("load5_run", m_obs, st(0, 1, 0, 4'(i)));
      tick();
    end
    chk("load5_done", m_obs, st(0, 0, 1, 0));
    tick();
    chk("load5_idle", m_obs, st(1, 0, 0, 0));

    // Load 0: done immediately, never busy.
    m_load_valid = 1'b1; m_load_value = 4'd0;
    tick();
    m_load_valid = 1'b0;
    chk("load0_done", m_obs, st(0, 0, 1, 0));
    tick();
    chk("load0_idle", m_obs, st(1, 0, 0, 0));

    // Load 3 with two paused edges at count 2.
    m_load_valid = 1'b1; m_load_value = 4'd3;
    tick();
    m_load_valid = 1'b0;
    chk("pause_3", m_obs, st(0, 1, 0, 3));
    tick();
    chk("pause_2", m_obs, st(0, 1, 0, 2));
    m_pause = 1'b1;
    tick();
    chk("pause_hold1", m_obs, st(0, 1, 0, 2));
    tick();
    chk("pause_hold2", m_obs, st(0, 1, 0, 2));
    m_pause = 1'b0;
    tick();
    chk("pause_1", m_obs, st(0, 1, 0, 1));
    tick();
    chk("pause_done", m_obs, st(0, 0, 1, 0));
    tick();
    chk("pause_idle", m_obs, st(1, 0, 0, 0));

    // Load 15, abort+pause together at count 9.
    m_load_valid = 1'b1; m_load_value = 4'd15;
    tick();
    m_load_valid = 1'b0;
    repeat (6) tick();
    chk("abort_at9", m_obs, st(0, 1, 0, 9));
    m_abort = 1'b1; m_pause = 1'b1;
    tick();
    m_abort = 1'b0; m_pause = 1'b0;
    chk("abort_idle", m_obs, st(1, 0, 0, 0));
    tick();
    chk("abort_no_done", m_obs, st(1, 0, 0, 0));

    // Same with reset at count 9.
    m_load_valid = 1'b1; m_load_value = 4'd15;
    tick();
    m_load_valid = 1'b0;
    repeat (6) tick();
    chk("rst_at9", m_obs, st(0, 1, 0, 9));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_idle", m_obs, st(1, 0, 0, 0));
    tick();
    chk("rst_no_done", m_obs, st(1, 0, 0, 0));

    // load_valid held high with a new value: ignored until back in IDLE.
    m_load_valid = 1'b1; m_load_value = 4'd4;
    tick();
    m_load_value = 4'd9;
    for (int i = 4; i >= 1; i--) begin
      chk("held_run", m_obs, st(0, 1, 0, 4'(i)));
      tick();
    end
    chk("held_done", m_obs, st(0, 0, 1, 0));
    tick();
    chk("held_idle", m_obs, st(1, 0, 0, 0));
    tick();
    chk("held_reload9", m_obs, st(0, 1, 0, 9));
    m_load_valid = 1'b0;
    m_abort = 1'b1;
    tick();
    m_abort = 1'b0;
    chk("held_abort", m_obs, st(1, 0, 0, 0));

    // Latency sweep: done appears V+1 cycles after acceptance, bounded wait.
    for (int v = 0; v < 16; v++) begin
      m_load_valid = 1'b1; m_load_value = 4'(v);
      tick();
      m_load_valid = 1'b0;
      n = 7'd1;
      while (!m_done && n < 7'd20) begin
        tick();
        n++;
      end
      chk("sweep_latency", n, 7'(v + 1));
      chk("sweep_done", m_obs, st(0, 0, 1, 0));
      tick();
      chk("sweep_idle", m_obs, st(1, 0, 0, 0));
    end

    // Auto-reload: load 2 -> 2,1,done,2,1,done; pause ignored in DONE.
    a_load_valid = 1'b1; a_load_value = 4'd2;
    tick();
    a_load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("ar_2", a_obs, st(0, 1, 0, 2));
      tick();
      chk("ar_1", a_obs, st(0, 1, 0, 1));
      tick();
      chk("ar_done", a_obs, st(0, 0, 1, 0));
      if (k == 1) a_pause = 1'b1;
      tick();
    end
    a_pause = 1'b0;
    chk("ar_reload", a_obs, st(0, 1, 0, 2));
    tick();
    chk("ar_1b", a_obs, st(0, 1, 0, 1));
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("ar_abort", a_obs, st(1, 0, 0, 0));
    tick();
    chk("ar_abort_hold", a_obs, st(1, 0, 0, 0));

    // Auto-reload with 0: single done then IDLE.
    a_load_valid = 1'b1; a_load_value = 4'd0;
    tick();
    a_load_valid = 1'b0;
    chk("ar0_done", a_obs, st(0, 0, 1, 0));
    tick();
    chk("ar0_idle", a_obs, st(1, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
